// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sender.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } morse_state_e;

    localparam logic [1:0] DOT_UNITS  = 2'd1;
    localparam logic [1:0] DASH_UNITS = 2'd3;
    localparam logic [1:0] GAP_UNITS  = 2'd1;
    localparam logic [2:0] MAX_LEN    = 3'd4;

    // Letters never hold more than four symbols; longer requests play as four.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len > MAX_LEN) begin
            return MAX_LEN;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Prescaler issuing one tick every TICK_DIV cycles, restartable by a synchronous clear.
module morse_tick_gen
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Count 0..TICK_DIV-1, wrapping on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == TERM) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Decoded from the count register only, so the FSM can use it to build clear.
    assign tick = (cnt_r == TERM);

endmodule

// File: rtl/morse_sender_ctrl.sv
// Plays one latched Morse letter on an LED: dots, dashes and inter-symbol gaps.
module morse_sender_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] code_i,
    input  logic [2:0] len_i,
    output logic       led_o,
    output logic       busy_o,
    output logic       done_o
);

    morse_state_e state_r;
    morse_state_e next_state_s;
    logic [3:0]   code_r;
    logic [2:0]   len_r;
    logic [1:0]   idx_r;
    logic [1:0]   unit_r;
    logic [1:0]   sym_units_s;
    logic [2:0]   start_len_s;
    logic         tick_s;
    logic         clear_s;
    logic         last_sym_s;
    logic         led_r;
    logic         busy_r;
    logic         done_r;

    assign start_len_s = clamp_len(len_i);
    assign sym_units_s = code_r[idx_r] ? DASH_UNITS : DOT_UNITS;
    assign last_sym_s  = ({1'b0, idx_r} == (len_r - 3'd1));

    // Counters restart on every state entry so each state lasts exactly its unit count.
    assign clear_s = (next_state_s != state_r) || (state_r == IDLE);

    morse_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    next_state_s = (start_len_s == 3'd0) ? DONE : ON;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ON: begin
                if (tick_s && (unit_r == sym_units_s - 2'd1)) begin
                    next_state_s = last_sym_s ? DONE : GAP;
                end else begin
                    next_state_s = ON;
                end
            end
            GAP: begin
                if (tick_s && (unit_r == GAP_UNITS - 2'd1)) begin
                    next_state_s = ON;
                end else begin
                    next_state_s = GAP;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Letter latch, symbol index and unit counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code_r <= 4'd0;
            len_r  <= 3'd0;
            idx_r  <= 2'd0;
            unit_r <= 2'd0;
        end else begin
            if ((state_r == IDLE) && start_i) begin
                code_r <= code_i;
                len_r  <= start_len_s;
                idx_r  <= 2'd0;
            end else if ((state_r == GAP) && (next_state_s == ON)) begin
                idx_r <= idx_r + 2'd1;
            end
            if (clear_s) begin
                unit_r <= 2'd0;
            end else if (tick_s) begin
                unit_r <= unit_r + 2'd1;
            end
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            led_r  <= (next_state_s == ON);
            busy_r <= (next_state_s == ON) || (next_state_s == GAP);
            done_r <= (next_state_s == DONE);
        end
    end

    assign led_o  = led_r;
    assign busy_o = busy_r;
    assign done_o = done_r;

endmodule

// File: tb/tb_morse_sender_ctrl.sv
// Bench for morse_sender_ctrl: per-cycle reference waveform plus hand-computed letter checks.
module tb_morse_sender_ctrl;

    localparam int TD = 4;

    typedef struct packed {
        logic led;
        logic busy;
        logic done;
    } exp_t;

    logic       clk;
    logic       rst_ni;
    logic       start_i;
    logic [3:0] code_i;
    logic [2:0] len_i;
    logic       led_o;
    logic       busy_o;
    logic       done_o;

    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t cur_exp;

    morse_sender_ctrl #(
        .TICK_DIV(TD)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .start_i(start_i),
        .code_i (code_i),
        .len_i  (len_i),
        .led_o  (led_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
        end
    endfunction

    // Expand a letter into its full per-cycle waveform from the timing rules.
    function automatic void build(input logic [3:0] c, input logic [2:0] l);
        int n;
        int u;
        n = (l > 3'd4) ? 4 : int'(l);
        for (int s = 0; s < n; s++) begin
            u = c[s] ? 3 : 1;
            for (int j = 0; j < u * TD; j++) exp_q.push_back(exp_t'(3'b110));
            if (s < n - 1) begin
                for (int j = 0; j < TD; j++) exp_q.push_back(exp_t'(3'b010));
            end
        end
        exp_q.push_back(exp_t'(3'b001));
    endfunction

    // Reference: accept a start only when the previous cycle was idle (not playing, not done).
    initial begin
        cur_exp = '0;
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                exp_q.delete();
                cur_exp = '0;
            end else begin
                if ((exp_q.size() == 0) && !cur_exp.done && (start_i === 1'b1)) build(code_i, len_i);
                if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
                else cur_exp = '0;
            end
        end
    end

    // Every-cycle comparison against the reference.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_led", {31'd0, led_o}, {31'd0, cur_exp.led});
            chk("cyc_busy", {31'd0, busy_o}, {31'd0, cur_exp.busy});
            chk("cyc_done", {31'd0, done_o}, {31'd0, cur_exp.done});
        end
    end

    task automatic play(input logic [3:0] c, input logic [2:0] l, input int e_led, input int e_busy,
                        input int e_done, input int pulse_at, input string nm);
        int led_n;
        int busy_n;
        int done_n;
        int done_at;
        @(posedge clk); #1;
        code_i = c; len_i = l; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; code_i = ~c; len_i = 3'd3;
        led_n = 0; busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 1; i <= e_done + 8; i++) begin
            @(negedge clk);
            if (led_o === 1'b1) led_n++;
            if (busy_o === 1'b1) busy_n++;
            if (done_o === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            start_i = (i == pulse_at) ? 1'b1 : 1'b0;
        end
        chk({nm, "_led_cycles"}, led_n, e_led);
        chk({nm, "_busy_cycles"}, busy_n, e_busy);
        chk({nm, "_done_cycle"}, done_at, e_done);
        chk({nm, "_done_count"}, done_n, 1);
    endtask

    initial begin
        int d1;
        int d2;
        int dn;
        total = 0; bad = 0;
        rst_ni = 1'b0; start_i = 1'b0; code_i = 4'd0; len_i = 3'd0;
        repeat (3) @(negedge clk);
        #1 rst_ni = 1'b1;
        chk("reset_led", {31'd0, led_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_done", {31'd0, done_o}, 32'd0);

        play(4'b0010, 3'd2, 16, 20, 21, 0, "letter_a");
        play(4'b0000, 3'd4, 16, 28, 29, 0, "letter_h");
        play(4'b0000, 3'd1, 4, 4, 5, 0, "letter_e");
        play(4'b1010, 3'd0, 0, 0, 1, 0, "zero_len");
        play(4'b1111, 3'd7, 48, 60, 61, 20, "clamp_ignore");

        // Reset in the middle of a dash.
        @(posedge clk); #1;
        code_i = 4'b0001; len_i = 3'd1; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_led", {31'd0, led_o}, 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("mid_rst_led", {31'd0, led_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_done", {31'd0, done_o}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_ni = 1'b1;
        play(4'b0010, 3'd2, 16, 20, 21, 0, "after_rst_a");

        // Start held high: A then H, with inputs switched mid-letter.
        @(posedge clk); #1;
        code_i = 4'b0010; len_i = 3'd2; start_i = 1'b1;
        @(posedge clk);
        d1 = -1; d2 = -1; dn = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                dn++;
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
            if (i == 3) begin
                code_i = 4'b0000; len_i = 3'd4;
            end
        end
        start_i = 1'b0;
        chk("b2b_first_done", d1, 21);
        chk("b2b_second_done", d2, 51);
        chk("b2b_done_count", dn, 2);
        repeat (40) @(negedge clk);
        chk("final_idle_busy", {31'd0, busy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_sender_ctrl.md
# morse_sender_ctrl

Sequences one Morse letter onto a single LED. Sits after the Morse letter decoder: it latches a 4-bit symbol code and a 3-bit length on a start request, then plays the symbols. A dot is 1 time unit on, a dash is 3 units on, and symbols are separated by 1 unit off. It reports busy while playing and pulses done when the letter finishes.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per time unit (0.5 s at 50 MHz). Minimum 1; benches override it to a small value.
- `clk_i` input 1: system clock; all state changes on its rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `start_i` input 1: request to play a letter; sampled only in IDLE.
- `code_i` input 4: symbol bits; bit0 is sent first; 0 = dot, 1 = dash.
- `len_i` input 3: number of symbols, 0..4; values 5..7 are clamped to 4.
- `led_o` output 1: Morse light; high only while a symbol is on.
- `busy_o` output 1: high while playing (ON and GAP states).
- `done_o` output 1: one-cycle pulse when a letter completes.

## Operation
- States: IDLE, ON, GAP, DONE. All outputs are decoded from registered state, so there are no combinational paths from inputs to outputs.
- **IDLE with start_i=1:**
  - Latch `code_i`, `len_i` (after clamping) and set the symbol index to 0.
  - If the clamped length is 0, go to DONE. Otherwise go to ON.
- **ON:**
  - `led_o`=1.
  - Duration is (code[idx] ? 3 : 1) × `TICK_DIV` cycles.
  - Then, if idx = len−1, go to DONE. Otherwise go to GAP.
- **GAP:**
  - `led_o`=0.
  - Duration is 1 × `TICK_DIV` cycles.
  - Then idx increments and the block goes to ON.
- **DONE:** `done_o`=1 for exactly one cycle, then IDLE.
- `start_i` is ignored in ON, GAP and DONE; no queuing. Input changes after the latch have no effect on the letter in flight.
- Timing counters:
  - Prescaler counts 0..`TICK_DIV`−1 and issues a tick on the terminal count.
  - Unit counter counts 0..2.
  - Both clear on every state entry, so each state's duration is exact and independent of history.
- Prescaler width is $clog2(`TICK_DIV`+1). Unit counter is 2 bits. Index is 2 bits; no wrap, because it stops at len−1 ≤ 3.
- **Reset (asynchronous, any state, including mid-symbol):**
  - State goes to IDLE; counters, index and latches clear.
  - `led_o`, `busy_o` and `done_o` go to 0 immediately.
  - The first rising edge after reset release can accept `start_i`.

## Timing
- Start accepted at edge k. From cycle k+1 the block is in ON with `led_o`=1 and `busy_o`=1 (1-cycle latency).
- Letter duration: `busy_o` high for `TICK_DIV` × (Σ symbol units + (len−1)) cycles. `done_o` is high in the following cycle, with `busy_o`=0 in that cycle.
- The earliest next start is accepted in the cycle after `done_o`, which is IDLE.
- With `TICK_DIV`=1 every unit is one cycle; no state may last zero cycles.
- `len_i`=0: `done_o` at k+1, with `busy_o` and `led_o` never asserted.

## Structure
- Package `morse_pkg`:
  - State enum `morse_state_e` {IDLE, ON, GAP, DONE}.
  - Constants DOT_UNITS=1, DASH_UNITS=3, GAP_UNITS=1, MAX_LEN=4.
- Sub-module `morse_tick_gen`: parameterised prescaler with inputs clk, rst_n and synchronous clear, and a one-cycle tick output.
- The FSM, unit counter and index live in `morse_sender_ctrl`.

## Test plan
- **Letter A** (`TICK_DIV`=4, code=0010, len=2, start at cycle 0) requires:
  - `led_o` high in cycles 1–4, low 5–8, high 9–20.
  - `done_o` in cycle 21.
  - `busy_o` high in cycles 1–20.
- **Letter H** (code=0000, len=4, `TICK_DIV`=4) requires four 4-cycle pulses separated by 4-cycle gaps, `busy_o` for 28 cycles, then `done_o`.
- **Letter E** (len=1) gives one 4-cycle pulse with no gap, and `done_o` in cycle 5. **Zero length** (len=0) gives `done_o` in cycle 1 and no `led_o`.
- **Clamp and ignored start:**
  - len=7 with code=1111 plays four dashes: 12 on / 4 off ×3, then 12 on.
  - `start_i` pulsed mid-letter is ignored, with no extra letter afterwards.
- **Reset mid-operation:** `rst_ni` asserted in the middle of a dash forces `led_o`=`busy_o`=`done_o`=0 immediately. After release, a new start plays a full letter from symbol 0.
- **Back-to-back letters:** start held high continuously gives a new letter beginning the cycle after each `done_o`, and inputs changed mid-letter do not alter the current letter.
